// File: rtl/map_pkg.sv
// Shared types and defaults for the MAP forward/backward recursion controllers.
package map_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CALC     = 4'd1,
    ST_WRITE    = 4'd2,
    ST_CHK      = 4'd3,
    ST_DONE     = 4'd4,
    ST_WAIT_RB  = 4'd5,
    ST_READBACK = 4'd6,
    ST_STOP     = 4'd7
  } map_state_t;

  localparam int MAP_ADDR_W   = 8;
  localparam int MAP_STRIDE   = 8;
  localparam int MAP_RB_START = 68;
  localparam int MAP_RB_END   = 79;

  // Width of a counter running 0..lat-1; never narrower than one bit.
  function automatic int lat_cnt_w(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/map_addr_gen.sv
// Alpha-SRAM address register with load / increment / hold control.
// With FWD_ADDR_CHK_EN defined, an increment past 2^ADDR_W-1 is refused and flagged on ovf.
module map_addr_gen
  import map_pkg::*;
#(
  parameter int ADDR_W    = MAP_ADDR_W,
  parameter int STRIDE    = MAP_STRIDE,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              ovf
);

  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] addr_next;

`ifdef FWD_ADDR_CHK_EN
  logic [ADDR_W:0] sum_wide;
  assign sum_wide  = {1'b0, addr_reg} + (ADDR_W+1)'(STRIDE);
  assign addr_next = sum_wide[ADDR_W-1:0];
  assign ovf       = sum_wide[ADDR_W];
`else
  assign addr_next = addr_reg + ADDR_W'(STRIDE);
  assign ovf       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg <= ADDR_W'(BASE_ADDR);
    end else if (load) begin
      addr_reg <= load_val;
    end else if (inc && !ovf) begin
      addr_reg <= addr_next;
    end
  end

  assign addr = addr_reg;

endmodule

// File: rtl/map_fwd_ctrl.sv
// Forward (alpha) recursion controller: step sequencing, done pulse and timed readback.
// Optional address-range error exit is compiled in with FWD_ADDR_CHK_EN.
module map_fwd_ctrl
  import map_pkg::*;
#(
  parameter int ADDR_W    = MAP_ADDR_W,
  parameter int STRIDE    = MAP_STRIDE,
  parameter int BASE_ADDR = 0,
  parameter int STEP_W    = 4,
  parameter int CALC_LAT  = 2,
  parameter int CNT_W     = 8,
  parameter int RB_START  = MAP_RB_START,
  parameter int RB_END    = MAP_RB_END
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [STEP_W-1:0] num_steps,
  input  logic [CNT_W-1:0]  count_main,
  output logic              w_r,
  output logic [ADDR_W-1:0] ad_addr,
  output logic              done_fwd,
  output logic              rb_valid,
  output logic              stop,
  output logic              busy,
  output logic              err
);

  localparam int LAT_W        = lat_cnt_w(CALC_LAT);
  localparam bit RB_ONE_CYCLE = (RB_START == RB_END);

  map_state_t        state_reg;
  logic [STEP_W-1:0] nsteps_reg;
  logic [STEP_W-1:0] step_cnt_reg;
  logic [LAT_W-1:0]  lat_cnt_reg;
  logic              w_r_reg;
  logic              done_reg;
  logic              rb_valid_reg;
  logic              stop_reg;
  logic              busy_reg;
  logic              err_reg;

  logic              addr_load;
  logic              addr_inc;
  logic              addr_ovf;
  logic [ADDR_W-1:0] addr_load_val;
  logic              start_ok;
  logic              rb_hit;
  logic              rb_last;

  assign start_ok = start && (state_reg == ST_IDLE || state_reg == ST_STOP);
  assign rb_hit   = (count_main == CNT_W'(RB_START));
  assign rb_last  = RB_ONE_CYCLE || (count_main == CNT_W'(RB_END));

  // Address commands must act on the same edge as the state transition.
  always_comb begin
    addr_load     = 1'b0;
    addr_load_val = ADDR_W'(BASE_ADDR);
    addr_inc      = 1'b0;
    if (start_ok) begin
      addr_load = 1'b1;
    end else if (state_reg == ST_WAIT_RB && rb_hit) begin
      addr_load     = 1'b1;
      addr_load_val = ADDR_W'(BASE_ADDR + STRIDE);
    end else if (state_reg == ST_WRITE || state_reg == ST_READBACK) begin
      addr_inc = 1'b1;
    end
  end

  map_addr_gen #(
    .ADDR_W   (ADDR_W),
    .STRIDE   (STRIDE),
    .BASE_ADDR(BASE_ADDR)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (addr_load),
    .load_val(addr_load_val),
    .inc     (addr_inc),
    .addr    (ad_addr),
    .ovf     (addr_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      nsteps_reg   <= '0;
      step_cnt_reg <= '0;
      lat_cnt_reg  <= '0;
      w_r_reg      <= 1'b0;
      done_reg     <= 1'b0;
      rb_valid_reg <= 1'b0;
      stop_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      w_r_reg  <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_STOP: begin
          if (start) begin
            nsteps_reg   <= num_steps;
            step_cnt_reg <= '0;
            lat_cnt_reg  <= '0;
            busy_reg     <= 1'b1;
            stop_reg     <= 1'b0;
            err_reg      <= 1'b0;
            rb_valid_reg <= 1'b0;
            if (num_steps == '0) begin
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              state_reg <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (lat_cnt_reg == LAT_W'(CALC_LAT - 1)) begin
            lat_cnt_reg <= '0;
            state_reg   <= ST_WRITE;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 1'b1;
          end
        end
        ST_WRITE: begin
          if (addr_ovf) begin
            err_reg   <= 1'b1;
            stop_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_STOP;
          end else begin
            w_r_reg      <= 1'b1;
            step_cnt_reg <= step_cnt_reg + 1'b1;
            state_reg    <= ST_CHK;
          end
        end
        ST_CHK: begin
          if (step_cnt_reg < nsteps_reg) begin
            state_reg <= ST_CALC;
          end else begin
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: state_reg <= ST_WAIT_RB;
        ST_WAIT_RB: begin
          if (rb_hit) begin
            rb_valid_reg <= 1'b1;
            state_reg    <= ST_READBACK;
          end
        end
        ST_READBACK: begin
          if (addr_ovf || rb_last) begin
            err_reg      <= addr_ovf;
            rb_valid_reg <= 1'b0;
            stop_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= ST_STOP;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign w_r      = w_r_reg;
  assign done_fwd = done_reg;
  assign rb_valid = rb_valid_reg;
  assign stop     = stop_reg;
  assign busy     = busy_reg;
  assign err      = err_reg;

endmodule

// File: doc/map_fwd_ctrl.md
Name: map_fwd_ctrl

Overview:
- Parametrised controller for the forward (alpha) recursion of the MAP decoder.
- Sequences alpha-SRAM addressing and write strobes across a runtime-programmable number of trellis steps, with a configurable compute latency per step.
- After the recursion it signals completion, waits for a programmable point on the global main counter, then streams stored alpha addresses back for the LLR stage.
- Supports re-start without reset, so multiple frames can be processed back to back.

Parameters:
- ADDR_W, 8, alpha-SRAM address width.
- STRIDE, 8, address increment per trellis stage (one stage = STRIDE state metrics).
- BASE_ADDR, 0, address of stage-0 alpha (initial metrics).
- STEP_W, 4, width of the runtime step-count input.
- CALC_LAT, 2, cycles of add/compare between read and write (minimum 1).
- CNT_W, 8, width of the main counter input.
- RB_START, 68, count_main value that starts readback.
- RB_END, 79, count_main value that ends readback.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle start pulse; ignored unless state is IDLE or STOP.
- num_steps  in  STEP_W  trellis steps to run; sampled on an accepted start.
- count_main  in  CNT_W  global main counter.
- w_r  out  1  1 = write alpha to SRAM, 0 = read.
- ad_addr  out  ADDR_W  alpha-SRAM address.
- done_fwd  out  1  one-cycle pulse when the recursion completes.
- rb_valid  out  1  high while ad_addr carries a readback address.
- stop  out  1  high once readback has finished.
- busy  out  1  high from an accepted start until STOP is entered.
- err  out  1  address-range error (see Optional Feature); tied 0 when the feature is off.

Behaviour:
- Reset values: state IDLE; w_r, done_fwd, rb_valid, stop, busy, err = 0; ad_addr = BASE_ADDR; step_cnt = 0; lat_cnt = 0. Reset wins over every other event, including a reset mid-recursion or mid-readback.
- IDLE:
  - On start: latch num_steps into nsteps_q, set busy=1, w_r=0, ad_addr=BASE_ADDR, step_cnt=0.
  - Go to DONE if num_steps==0, otherwise to CALC.
- CALC: hold for exactly CALC_LAT cycles (lat_cnt counts 0..CALC_LAT-1), then go to WRITE. w_r stays 0.
- WRITE (one cycle): ad_addr += STRIDE (mod 2^ADDR_W), w_r=1, step_cnt += 1, go to CHK.
- CHK: w_r=0. If step_cnt < nsteps_q go to CALC (lat_cnt=0), else go to DONE.
- DONE: done_fwd=1 for exactly one cycle, go to WAIT_RB.
- WAIT_RB:
  - done_fwd=0.
  - When count_main==RB_START: ad_addr=BASE_ADDR+STRIDE, rb_valid=1, go to READBACK.
- READBACK:
  - ad_addr += STRIDE every cycle.
  - When count_main==RB_END: rb_valid=0, stop=1, busy=0, go to STOP.
  - The increment still occurs on the exit cycle.
- STOP:
  - stop holds 1 and ad_addr holds its last value.
  - A start here clears stop and behaves exactly as start in IDLE (frame re-arm).
- Step timing: CALC_LAT+2 cycles per step. The recursion takes nsteps_q*(CALC_LAT+2)+1 cycles from start to the done_fwd pulse.
- start while busy is ignored; no error is flagged.
- If count_main already equals RB_START when WAIT_RB is entered, readback starts on that same cycle.
- If RB_START==RB_END, READBACK lasts exactly one cycle.
- Address arithmetic is unsigned ADDR_W and wraps modulo 2^ADDR_W when FWD_ADDR_CHK_EN is undefined.

Optional Feature:
- Macro: FWD_ADDR_CHK_EN.
- Defined:
  - In WRITE and READBACK, if ad_addr+STRIDE would exceed 2^ADDR_W-1, ad_addr holds, err is set (sticky until rst or an accepted start), and the FSM jumps to STOP with stop=1 and busy=0.
  - done_fwd is not pulsed on an error exit.
- Undefined: err is tied 0 and addresses wrap silently.

Decomposition:
- Shared package map_pkg:
  - FSM state enum (IDLE, CALC, WRITE, CHK, DONE, WAIT_RB, READBACK, STOP), 4-bit encoded.
  - Default RB_START/RB_END constants.
  - Alpha-SRAM ADDR_W/STRIDE defaults, shared with the backward-recursion controller.
- One sub-module is natural: map_addr_gen, holding the ad_addr register with load/increment/hold controls and the optional range check. The FSM drives it.

Test Plan:
- Default params, start with num_steps=7 → w_r pulses at cycles 4,8,...,28 after start with ad_addr=8,16,...,56; done_fwd pulses once at cycle 29.
- count_main ramps 0..90 after done → rb_valid rises at count_main=68 with ad_addr=8, addresses step by 8, stop=1 at count_main=79, busy=0.
- num_steps=0 → no w_r pulse; done_fwd pulses on cycle 1 after start.
- rst asserted mid-CALC at step 3 → next cycle all outputs return to their reset values; a following start re-runs cleanly from ad_addr=0.
- CALC_LAT=4, num_steps=3 → 6 cycles per step; start pulses during busy are ignored; a start while in STOP re-arms the block and clears stop.
- FWD_ADDR_CHK_EN defined, STRIDE=64, num_steps=5 → fourth WRITE would overflow 255: err=1, stop=1, no done_fwd, ad_addr holds 192.
